pipe_field: RTL
===============

PIPE_FIELD -- requirements
Module: pipe_field

Interface
REQ-001 SHALL have port Clock  input  1  system clock, all state updates on posedge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high; clock Clock.
REQ-003 SHALL have port start  input  1  global run enable; when 0, every register holds.
REQ-004 SHALL have port tick  input  1  one-cycle scroll strobe.
REQ-005 SHALL have port birdPos  input  8  one-hot bird row from the bird movement controller; bit7 bottom, bit0 top, 0 = no bird.
REQ-006 SHALL have port gameOver  input  1  bird fell off the field.
REQ-007 SHALL have port crash  output  1  registered, sticky collision flag fed back to the bird controller.
REQ-008 SHALL have port grid  output  64  field image; column c = grid[8c+7:8c], c=0 leftmost, 1 = pipe pixel.
REQ-009 SHALL have port scoreOnes  output  4  BCD units of pipes passed.
REQ-010 SHALL have port scoreTens  output  4  BCD tens of pipes passed.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, OVER; all transitions gated by start=1.
REQ-012 IDLE->RUN SHALL occur on the first tick; that tick SHALL be processed as a RUN scroll.
REQ-013 In RUN, hit = |(birdPos & col[BIRD_COL]) with BIRD_COL=1, evaluated every cycle.
REQ-014 RUN with hit SHALL go to OVER, set crash=1 next cycle, and suppress any same-cycle scroll and score.
REQ-015 RUN with gameOver=1 and no hit SHALL go to OVER with crash left 0; a same-cycle tick SHALL be ignored.
REQ-016 OVER SHALL be terminal until reset: grid, score, LFSR, crash frozen.
REQ-017 A RUN scroll SHALL shift col[c] <= col[c+1] for c=0..6 and load col[7] with the new column.
REQ-018 A 2-bit spacing counter SHALL advance per scroll; new column = pipe when counter==3 (then wraps to 0), else 8'h00.
REQ-019 An 8-bit Fibonacci LFSR, seed 8'hA5, SHALL shift per scroll: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}; insertion uses the pre-shift value.
REQ-020 Gap row g = lfsr[2:0] if <=5, else lfsr[2:0]-3; pipe column = ~(8'b0000_0111 << g), giving a 3-row gap at rows g..g+2.
REQ-021 On a scroll with col[1] nonzero and no hit, score SHALL increment in BCD (09->10), saturating at 99.
REQ-022 grid, crash, score SHALL be direct register outputs (no combinational path from inputs).

Reset
REQ-023 reset SHALL force state=IDLE, grid=64'h0, crash=0, score=00, spacing counter=0, lfsr=8'hA5; reset has priority over start.
REQ-024 reset mid-game (RUN or OVER) SHALL restore REQ-023 values on the next edge with no residual state.

Structure
REQ-025 A shared package SHALL hold the state enum, BIRD_COL=1, GAP_H=3, PIPE_SPACING=4, LFSR_SEED=8'hA5, LFSR tap constants.
REQ-026 Score SHALL be a sub-module bcd_score_counter (Clock, reset, inc -> ones, tens, saturating at 99).
REQ-027 LFSR, shift field, spacing counter and FSM SHALL reside in pipe_field.

Verification
REQ-028 Reset, start=1, birdPos=8'h10, 3 ticks -> grid=0, score=00; tick4 -> col7=8'hE3 (lfsr 8'h2A, g=2).
REQ-029 Continue to tick10 -> col1=8'hE3, crash=0; tick11 -> col0=8'hE3, score=01.
REQ-030 Same run but birdPos=8'h01 at col1=8'hE3 -> crash=1 one cycle later, state OVER, further ticks leave grid unchanged.
REQ-031 start=0 during ticks -> grid, lfsr, score held; gameOver=1 in RUN -> OVER, crash stays 0.
REQ-032 Preload score to 99 via long run -> next passed pipe keeps 99; tick and hit in same cycle -> no shift, crash=1.
REQ-033 reset asserted in OVER with crash=1 -> next cycle all outputs at REQ-023 values.

Source files
------------

// File: rtl/pipe_field_pkg.sv
// Shared definitions for the scrolling pipe field: FSM states, geometry
// constants, LFSR parameters and the gap/pipe-column helpers.
package pipe_field_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OVER = 2'd2
   } state_t;

   localparam int unsigned ROWS         = 8;
   localparam int unsigned COLS         = 8;
   localparam int unsigned GRID_W       = ROWS * COLS;
   localparam int unsigned BIRD_COL     = 1;
   localparam int unsigned GAP_H        = 3;
   localparam int unsigned PIPE_SPACING = 4;
   localparam int unsigned SPACE_W      = 2;

   localparam logic [7:0] LFSR_SEED = 8'hA5;
   // Feedback taps: bits 7, 5, 4, 3.
   localparam logic [7:0] LFSR_TAPS = 8'hB8;
   localparam logic [7:0] GAP_MASK  = 8'((1 << GAP_H) - 1);

   // Top row of the 3-row gap; folds 6/7 back so the gap stays on-field.
   function automatic logic [2:0] gap_row(input logic [7:0] lfsr);
      logic [2:0] r;
      r = lfsr[2:0];
      return (r <= 3'd5) ? r : 3'(r - 3'd3);
   endfunction

   // Full pipe column with a gap at rows g..g+2.
   function automatic logic [7:0] pipe_column(input logic [7:0] lfsr);
      return ~8'(GAP_MASK << gap_row(lfsr));
   endfunction

   // Fibonacci shift: feedback enters at bit 0.
   function automatic logic [7:0] lfsr_next(input logic [7:0] lfsr);
      return {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/pipe_field_score.sv
// bcd_score_counter: two-digit BCD counter of pipes passed, saturating at 99.
// Ports: Clock, reset (sync, active-high), inc (count strobe),
//        ones / tens (registered BCD digits).
module bcd_score_counter (
   input  logic       Clock,
   input  logic       reset,
   input  logic       inc,
   output logic [3:0] ones,
   output logic [3:0] tens
);

   always_ff @(posedge Clock) begin
      if (reset) begin
         ones <= 4'd0;
         tens <= 4'd0;
      end else if (inc) begin
         if (ones != 4'd9) begin
            ones <= 4'(ones + 4'd1);
         end else if (tens != 4'd9) begin
            ones <= 4'd0;
            tens <= 4'(tens + 4'd1);
         end
      end
   end

endmodule

// File: rtl/pipe_field.sv
// pipe_field: 8x8 scrolling pipe field with collision detection and score.
// Ports: Clock, reset (sync, active-high), start (global run enable),
//        tick (scroll strobe), birdPos (one-hot bird row), gameOver (bird
//        fell off field) -> crash (sticky), grid (64-bit field image, column
//        c at grid[8c+7:8c]), scoreOnes / scoreTens (BCD pipes passed).
module pipe_field
   import pipe_field_pkg::*;
(
   input  logic              Clock,
   input  logic              reset,
   input  logic              start,
   input  logic              tick,
   input  logic [ROWS-1:0]   birdPos,
   input  logic              gameOver,
   output logic              crash,
   output logic [GRID_W-1:0] grid,
   output logic [3:0]        scoreOnes,
   output logic [3:0]        scoreTens
);

   state_t             state;
   logic [7:0]         lfsr;
   logic [SPACE_W-1:0] space_cnt;

   logic               hit_c;
   logic               scroll_c;
   logic               pass_c;
   logic [ROWS-1:0]    new_col_c;
   logic [ROWS-1:0]    bird_col_c;

   assign bird_col_c = grid[ROWS*BIRD_COL +: ROWS];

   // Collision only matters while running; the field is empty in IDLE.
   assign hit_c = (state == RUN) && (|(birdPos & bird_col_c));

   // A hit or gameOver pre-empts a same-cycle tick.
   assign scroll_c = start && tick &&
                     ((state == IDLE) || ((state == RUN) && !hit_c && !gameOver));

   // Pipe leaving the bird column this scroll has been passed.
   assign pass_c = scroll_c && (|bird_col_c);

   // Insertion uses the pre-shift LFSR value.
   assign new_col_c = (space_cnt == SPACE_W'(PIPE_SPACING - 1)) ? pipe_column(lfsr)
                                                                : '0;

   // FSM, field shift register, spacing counter and LFSR.
   always_ff @(posedge Clock) begin
      if (reset) begin
         state     <= IDLE;
         grid      <= '0;
         crash     <= 1'b0;
         space_cnt <= '0;
         lfsr      <= LFSR_SEED;
      end else if (start) begin
         case (state)
            IDLE: begin
               if (tick) state <= RUN;
            end
            RUN: begin
               if (hit_c) begin
                  state <= OVER;
                  crash <= 1'b1;
               end else if (gameOver) begin
                  state <= OVER;
               end
            end
            default: state <= state;
         endcase

         if (scroll_c) begin
            grid      <= {new_col_c, grid[GRID_W-1:ROWS]};
            space_cnt <= SPACE_W'(space_cnt + SPACE_W'(1));
            lfsr      <= lfsr_next(lfsr);
         end
      end
   end

   bcd_score_counter u_score (
      .Clock (Clock),
      .reset (reset),
      .inc   (pass_c),
      .ones  (scoreOnes),
      .tens  (scoreTens)
   );

endmodule
